// File: rtl/pulse_in_ctrl.sv
`timescale 1ns / 1ps
// Hardware pulseIn(): waits for the selected GPIO to go idle, catches the next pulse start and
// measures its width in prescaled ticks, with optional timeout and software abort.
module pulse_in_ctrl #(
  parameter int NUM_PINS    = 32,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] gpio_in_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SEL_W-1:0]    pin_sel_i,
  input  logic                level_i,
  input  logic [15:0]         prescale_i,
  input  logic [CNT_W-1:0]    timeout_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [CNT_W-1:0]    width_o
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, DONE} state_t;

  localparam logic [SEL_W:0] PIN_LIM = (SEL_W + 1)'(NUM_PINS);

  state_t              state;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [SEL_W-1:0]    cfg_pin;
  logic                cfg_lvl;
  logic [15:0]         cfg_pre;
  logic [CNT_W-1:0]    cfg_tmo;
  logic [15:0]         pre_cnt;
  logic [CNT_W-1:0]    width_cnt;
  logic [CNT_W-1:0]    tout_cnt;
  logic [CNT_W-1:0]    width_inc;
  logic [CNT_W-1:0]    tout_inc;
  logic                p;
  logic                p_d;
  logic                tick;
  logic                at_level;
  logic                rise;
  logic                tout_hit;
  logic                active;

  // Every pin is synchronised, so a newly selected pin is valid the cycle after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign p         = ({1'b0, cfg_pin} < PIN_LIM) ? sync_q[SYNC_STAGES-1][cfg_pin] : 1'b0;
  assign tick      = (pre_cnt == cfg_pre);
  assign at_level  = (p == cfg_lvl);
  assign rise      = at_level && (p_d != cfg_lvl);
  assign tout_hit  = (cfg_tmo != '0) && (tout_cnt == cfg_tmo);
  assign active    = (state == WAIT_IDLE) || (state == WAIT_START) || (state == MEASURE);
  assign width_inc = (tick && !(&width_cnt)) ? width_cnt + CNT_W'(1) : width_cnt;
  assign tout_inc  = (tick && !(&tout_cnt)) ? tout_cnt + CNT_W'(1) : tout_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      width_o   <= '0;
      cfg_pin   <= '0;
      cfg_lvl   <= 1'b0;
      cfg_pre   <= '0;
      cfg_tmo   <= '0;
      pre_cnt   <= '0;
      width_cnt <= '0;
      tout_cnt  <= '0;
      p_d       <= 1'b0;
    end else begin
      p_d    <= p;
      done_o <= 1'b0;
      if (active) begin
        pre_cnt  <= tick ? '0 : pre_cnt + 16'd1;
        tout_cnt <= tout_inc;
      end else begin
        pre_cnt <= '0;
      end

      if (state != IDLE && abort_i) begin
        state     <= IDLE;
        busy_o    <= 1'b0;
        width_o   <= '0;
        timeout_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cfg_pin   <= pin_sel_i;
              cfg_lvl   <= level_i;
              cfg_pre   <= prescale_i;
              cfg_tmo   <= timeout_i;
              width_o   <= '0;
              timeout_o <= 1'b0;
              tout_cnt  <= '0;
              pre_cnt   <= '0;
              busy_o    <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (tout_hit) begin
              state     <= DONE;
              done_o    <= 1'b1;
              timeout_o <= 1'b1;
              width_o   <= '0;
            end else if (!at_level) begin
              state <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (tout_hit) begin
              state     <= DONE;
              done_o    <= 1'b1;
              timeout_o <= 1'b1;
              width_o   <= '0;
            end else if (rise) begin
              state     <= MEASURE;
              width_cnt <= '0;
              pre_cnt   <= '0;
            end
          end
          MEASURE: begin
            // The tick of the terminating cycle still counts; pulse end beats a coincident timeout.
            if (!at_level) begin
              state   <= DONE;
              done_o  <= 1'b1;
              width_o <= width_inc;
            end else if (tout_hit) begin
              state     <= DONE;
              done_o    <= 1'b1;
              timeout_o <= 1'b1;
              width_o   <= '0;
            end else begin
              width_cnt <= width_inc;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_in_ctrl.sv
`timescale 1ns / 1ps
// Directed bench for pulse_in_ctrl: an arithmetic model predicts each measurement from the
// driven pin waveform, and a per-cycle compare process checks all outputs against it.
module tb_pulse_in_ctrl;
  localparam int NP  = 32;
  localparam int CW  = 32;
  localparam int DLY = 2;          // synchroniser depth seen by the FSM
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] gpio = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [4:0]    pin_sel = '0;
  logic          level = 1'b0;
  logic [15:0]   prescale = '0;
  logic [CW-1:0] timeout = '0;
  logic          busy;
  logic          done;
  logic          tout_o;
  logic [CW-1:0] width;

  always #20 clk = ~clk;

  pulse_in_ctrl #(.NUM_PINS(NP), .CNT_W(CW), .SYNC_STAGES(DLY)) dut (
    .clk(clk), .rst(rst), .gpio_in_i(gpio), .start_i(start), .abort_i(abort),
    .pin_sel_i(pin_sel), .level_i(level), .prescale_i(prescale), .timeout_i(timeout),
    .busy_o(busy), .done_o(done), .timeout_o(tout_o), .width_o(width)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  bit            chk_en  = 1'b0;
  bit            e_busy, e_done, e_tout;
  logic [CW-1:0] e_width;
  logic [CW-1:0] prev_w = '0;
  bit            prev_t = 1'b0;
  int            done_at;
  int            segs[$];
  bit            wv[];
  bit            w_init;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after each edge, against expectations set before that edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("timeout", tout_o, e_tout);
      check("width", width, e_width);
    end
  end

  function automatic bit pv(input int k);
    if (k < 0) return w_init;
    if (k >= wv.size()) return wv[wv.size()-1];
    return wv[k];
  endfunction

  // Pin waveform (relative to the start edge) is init for segs[0] cycles, then toggles per segment.
  // kill>=0 aborts (or resets when kill_rst) at that edge; spur>=0 fires a stray start + config change.
  task automatic run(input int pin, input bit lvl, input int pre, input int tmo, input bit init,
                     input int spur, input int kill, input bit kill_rst);
    int            len, k, a, e0, f, d, n0, t_t, t_d, last;
    bit            v;
    logic [CW-1:0] rw;
    bit            rt;

    len = (tmo + 2) * (pre + 1) + 64;
    foreach (segs[j]) len += segs[j];
    wv = new[len];
    v = init;
    k = 0;
    foreach (segs[j]) begin
      for (int c = 0; c < segs[j]; c++) begin wv[k] = v; k++; end
      v = ~v;
    end
    while (k < len) begin wv[k] = v; k++; end
    w_init = init;

    // Model: the FSM decides at edge e on the pin value sampled DLY edges earlier.
    a = BIG;
    for (int e = 1; e < len; e++) if (pv(e - DLY) != lvl) begin a = e; break; end
    e0 = BIG;
    for (int e = a + 1; e < len; e++)
      if (pv(e - DLY) == lvl && pv(e - DLY - 1) != lvl) begin e0 = e; break; end
    f = BIG;
    for (int e = e0 + 1; e < len; e++) if (pv(e - DLY) != lvl) begin f = e; break; end
    t_d = BIG;
    if (tmo != 0) begin
      n0  = (e0 == BIG) ? BIG : e0 / (pre + 1);
      t_t = (tmo <= n0) ? tmo * (pre + 1) : e0 + (tmo - n0) * (pre + 1);
      t_d = t_t + 1;
    end
    if (t_d < f) begin d = t_d; rw = '0; rt = 1'b1; end
    else begin d = f; rw = CW'((f - e0) / (pre + 1)); rt = 1'b0; end

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      gpio = '0; gpio[pin] = init; start = 1'b0; abort = 1'b0; rst = 1'b0;
      pin_sel = 5'(pin); level = lvl; prescale = 16'(pre); timeout = CW'(tmo);
      e_busy = 1'b0; e_done = 1'b0; e_width = prev_w; e_tout = prev_t;
    end

    last = (kill >= 0) ? kill + 4 : d + 4;
    done_at = -1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (done) done_at = i - 1;
      gpio = '0;
      gpio[pin] = wv[i];
      start = (i == 0) || (i == spur);
      if (spur >= 0 && i >= spur) begin
        gpio[7] = i[4];
        pin_sel = 5'd7; level = ~lvl; prescale = 16'd0; timeout = CW'(5);
      end
      abort = !kill_rst && (i == kill);
      rst   = kill_rst && (i == kill);
      if (kill >= 0) begin
        e_busy = (i < kill); e_done = 1'b0; e_width = '0; e_tout = 1'b0;
      end else begin
        e_busy  = (i <= d);
        e_done  = (i == d);
        e_width = (i >= d) ? rw : '0;
        e_tout  = (i >= d) ? rt : 1'b0;
      end
    end
    @(negedge clk);
    if (done) done_at = last;
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    prev_w = (kill >= 0) ? '0 : rw;
    prev_t = (kill >= 0) ? 1'b0 : rt;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    e_busy = 1'b0; e_done = 1'b0; e_width = '0; e_tout = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: 500 us high pulse on pin 4
    segs = '{100, 12500};
    run(4, 1'b1, 24, 0, 1'b0, -1, -1, 1'b0);
    check("t1_width", width, 500);
    check("t1_timeout", tout_o, 0);

    // 2: pulse already in progress at start is skipped
    segs = '{1250, 100, 7500};
    run(4, 1'b1, 24, 0, 1'b1, -1, -1, 1'b0);
    check("t2_width", width, 300);

    // 3: low pulse of 1000 us
    segs = '{100, 25000};
    run(4, 1'b0, 24, 0, 1'b1, -1, -1, 1'b0);
    check("t3_width", width, 1000);

    // 4: static pin times out after 100 ticks
    segs = {};
    run(4, 1'b1, 24, 100, 1'b0, -1, -1, 1'b0);
    check("t4_done_edge", done_at, 2501);
    check("t4_timeout", tout_o, 1);
    check("t4_width", width, 0);

    // 4b: pulse end and timeout in the same cycle -> valid width
    segs = '{48, 51};
    run(4, 1'b1, 24, 4, 1'b0, -1, -1, 1'b0);
    check("t4b_width", width, 2);
    check("t4b_timeout", tout_o, 0);

    // 4c: pulse one cycle longer -> timeout wins
    segs = '{48, 52};
    run(4, 1'b1, 24, 4, 1'b0, -1, -1, 1'b0);
    check("t4c_timeout", tout_o, 1);
    check("t4c_width", width, 0);

    // 5: stray start with other pin/config mid-measure is ignored
    segs = '{40, 2500};
    run(4, 1'b1, 24, 0, 1'b0, 1000, -1, 1'b0);
    check("t5_width", width, 100);

    // 5b: abort mid-measure
    segs = '{40, 2500};
    run(4, 1'b1, 24, 0, 1'b0, -1, 1000, 1'b0);
    check("t5b_done_seen", done_at, -1);
    check("t5b_busy", busy, 0);

    // 6: reset mid-measure, then a 7-cycle pulse with tick every cycle
    segs = '{40, 2500};
    run(4, 1'b1, 24, 0, 1'b0, -1, 500, 1'b1);
    check("t6_done_seen", done_at, -1);
    segs = '{10, 7};
    run(4, 1'b1, 0, 0, 1'b0, -1, -1, 1'b0);
    check("t6b_width", width, 7);
    check("t6b_done_edge", done_at, 19);

    chk_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
